// File: rtl/usb_rx_pkt_pkg.sv
// usb_rx_pkt_pkg: shared USB receive definitions.
// Holds PID constants, PID class encodings, receiver FSM states and the
// CRC5/CRC16 polynomials and good-packet residuals used by usb_rx_pkt.
package usb_rx_pkt_pkg;
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  typedef enum logic [1:0] {
    CLS_SPECIAL   = 2'b00,
    CLS_TOKEN     = 2'b01,
    CLS_HANDSHAKE = 2'b10,
    CLS_DATA      = 2'b11
  } pid_class_t;
  typedef enum logic [1:0] {IDLE, PID, PAYLOAD, ERR_WAIT} rx_state_t;
  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  // A PID byte is well formed when its upper nibble is the complement of the lower.
  function automatic logic pid_valid(input logic [7:0] b);
    return b[3:0] == ~b[7:4];
  endfunction
endpackage

// File: rtl/usb_rx_pkt_crc.sv
// usb_crc: serial LSB-first CRC with residual check.
// Ports: clk, rst (async, active-high); init reloads INIT; data_bit/en shift
// one bit in; match is high while the register equals RESIDUAL.
module usb_crc #(
  parameter int           W        = 5,
  parameter logic [W-1:0] POLY     = '0,
  parameter logic [W-1:0] INIT     = '1,
  parameter logic [W-1:0] RESIDUAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic data_bit,
  input  logic en,
  output logic match
);
  logic [W-1:0] crc;
  always_ff @(posedge clk or posedge rst)
    if (rst) crc <= INIT;
    else if (init) crc <= INIT;
    else if (en) crc <= {crc[W-2:0], 1'b0} ^ ((data_bit ^ crc[W-1]) ? POLY : '0);
  assign match = crc == RESIDUAL;
endmodule

// File: rtl/usb_rx_pkt.sv
// usb_rx_pkt: USB packet receive sequencer on the low-level ll_* bit stream.
// Ports: clk, rst (async, active-high); ll_bit/ll_valid/ll_eop/ll_sync/
// ll_bs_skip/ll_bs_err from the NRZI/destuff stage; rx_enable gates reception.
// Outputs: pkt_start/pkt_done_ok/pkt_done_err pulses, latched PID and class
// flags, token fields, and rx_data/rx_stb for every byte after a DATA PID.
module usb_rx_pkt
  import usb_rx_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ll_bit,
  input  logic        ll_valid,
  input  logic        ll_eop,
  input  logic        ll_sync,
  input  logic        ll_bs_skip,
  input  logic        ll_bs_err,
  input  logic        rx_enable,
  output logic        pkt_start,
  output logic        pkt_done_ok,
  output logic        pkt_done_err,
  output logic [3:0]  pkt_pid,
  output logic        pkt_is_sof,
  output logic        pkt_is_token,
  output logic        pkt_is_data,
  output logic        pkt_is_handshake,
  output logic [10:0] pkt_frameno,
  output logic [6:0]  pkt_addr,
  output logic [3:0]  pkt_endp,
  output logic [7:0]  rx_data,
  output logic        rx_stb
);
  localparam int CW = $clog2(MAX_PAYLOAD + 4);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PAYLOAD + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_PAYLOAD + 3);
  rx_state_t state, state_n;
  logic [6:0] sr;
  logic [2:0] bcnt;
  logic [CW-1:0] byte_cnt;
  logic [10:0] tok;
  logic [7:0] byte_val;
  logic keep, in_pkt, byte_done, over, len_ok, crc_ok, crc5_ok, crc16_ok;
  logic start_n, ok_n, err_n, crc_init, crc_en;
  pid_class_t cls;
  // A kept bit is a real data bit: strobed, not stuffed, not a framing event.
  assign keep      = ll_valid & rx_enable & ~ll_eop & ~ll_sync & ~ll_bs_skip & ~ll_bs_err;
  assign in_pkt    = state == PID || state == PAYLOAD;
  assign byte_val  = {ll_bit, sr};
  assign byte_done = in_pkt & keep & (bcnt == 3'd7);
  assign over      = byte_cnt >= CNT_MAX;
  assign crc_en    = state == PAYLOAD && keep;
  assign cls              = pid_class_t'(pkt_pid[1:0]);
  assign pkt_is_token     = cls == CLS_TOKEN;
  assign pkt_is_sof       = pkt_pid == PID_SOF;
  assign pkt_is_data      = cls == CLS_DATA;
  assign pkt_is_handshake = cls == CLS_HANDSHAKE;
  assign pkt_frameno      = tok;
  assign pkt_addr         = tok[6:0];
  assign pkt_endp         = tok[10:7];
  assign len_ok = pkt_is_handshake ? byte_cnt == '0 :
                  pkt_is_token     ? byte_cnt == CW'(2) :
                  pkt_is_data      ? (byte_cnt >= CW'(2) && byte_cnt <= CNT_MAX) : 1'b0;
  assign crc_ok = pkt_is_token ? crc5_ok : pkt_is_data ? crc16_ok : 1'b1;
  usb_crc #(.W(5), .POLY(CRC5_POLY), .INIT(5'h1F), .RESIDUAL(CRC5_RESIDUAL)) u_crc5 (
    .clk(clk), .rst(rst), .init(crc_init), .data_bit(ll_bit), .en(crc_en), .match(crc5_ok)
  );
  usb_crc #(.W(16), .POLY(CRC16_POLY), .INIT(16'hFFFF), .RESIDUAL(CRC16_RESIDUAL)) u_crc16 (
    .clk(clk), .rst(rst), .init(crc_init), .data_bit(ll_bit), .en(crc_en), .match(crc16_ok)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n  = state;
    start_n  = 1'b0;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    crc_init = 1'b0;
    if (!rx_enable) state_n = IDLE;
    else case (state)
      IDLE:
        if (ll_valid & ll_sync & ~ll_eop) begin
          state_n = PID;
          start_n = 1'b1;
        end
      PID:
        if (ll_valid & (ll_eop | ll_bs_err)) begin
          err_n   = 1'b1;
          state_n = ll_eop ? IDLE : ERR_WAIT;
        end else if (byte_done) begin
          state_n  = pid_valid(byte_val) ? PAYLOAD : ERR_WAIT;
          err_n    = ~pid_valid(byte_val);
          crc_init = pid_valid(byte_val);
        end
      PAYLOAD:
        if (ll_valid & ll_eop) begin
          ok_n    = bcnt == 3'd0 && !ll_bs_err && len_ok && crc_ok;
          err_n   = ~ok_n;
          state_n = IDLE;
        end else if ((ll_valid & ll_bs_err) | (byte_done & over)) begin
          err_n   = 1'b1;
          state_n = ERR_WAIT;
        end
      ERR_WAIT:
        if (ll_valid & ll_eop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pkt_start    <= 1'b0;
      pkt_done_ok  <= 1'b0;
      pkt_done_err <= 1'b0;
      sr           <= '0;
      bcnt         <= '0;
      byte_cnt     <= '0;
      pkt_pid      <= '0;
      tok          <= '0;
      rx_data      <= '0;
      rx_stb       <= 1'b0;
    end else begin
      pkt_start    <= start_n;
      pkt_done_ok  <= ok_n;
      pkt_done_err <= err_n;
      rx_stb       <= 1'b0;
      if (start_n) begin
        bcnt     <= '0;
        byte_cnt <= '0;
      end else if (in_pkt && keep) begin
        sr   <= byte_val[7:1];
        bcnt <= bcnt + 3'd1;
      end
      if (state == PID && byte_done) pkt_pid <= byte_val[3:0];
      if (state == PAYLOAD && byte_done) begin
        byte_cnt <= byte_cnt == CNT_SAT ? byte_cnt : byte_cnt + 1'b1;
        if (pkt_is_data) begin
          rx_data <= byte_val;
          rx_stb  <= 1'b1;
        end
        // Token fields arrive as byte 0 (bits 7:0) and the low 3 bits of byte 1.
        if (pkt_is_token && byte_cnt == CW'(0)) tok[7:0] <= byte_val;
        if (pkt_is_token && byte_cnt == CW'(1)) tok[10:8] <= byte_val[2:0];
      end
    end
endmodule

// File: tb/tb_usb_rx_pkt.sv
// tb_usb_rx_pkt: directed self-checking bench for usb_rx_pkt.
module tb_usb_rx_pkt;
  logic clk = 1'b0, rst = 1'b1;
  logic ll_bit = 0, ll_valid = 0, ll_eop = 0, ll_sync = 0, ll_bs_skip = 0, ll_bs_err = 0;
  logic rx_enable = 1'b1;
  logic pkt_start, pkt_done_ok, pkt_done_err, rx_stb;
  logic pkt_is_sof, pkt_is_token, pkt_is_data, pkt_is_handshake;
  logic [3:0] pkt_pid, pkt_endp;
  logic [10:0] pkt_frameno;
  logic [6:0] pkt_addr;
  logic [7:0] rx_data;
  int n_checks = 0, n_fail = 0;
  int start_cnt = 0, ok_cnt = 0, err_cnt = 0;
  int b_start, b_ok, b_err, b_q;
  logic [7:0] rx_q[$];

  usb_rx_pkt dut (
    .clk(clk), .rst(rst), .ll_bit(ll_bit), .ll_valid(ll_valid), .ll_eop(ll_eop),
    .ll_sync(ll_sync), .ll_bs_skip(ll_bs_skip), .ll_bs_err(ll_bs_err), .rx_enable(rx_enable),
    .pkt_start(pkt_start), .pkt_done_ok(pkt_done_ok), .pkt_done_err(pkt_done_err),
    .pkt_pid(pkt_pid), .pkt_is_sof(pkt_is_sof), .pkt_is_token(pkt_is_token),
    .pkt_is_data(pkt_is_data), .pkt_is_handshake(pkt_is_handshake),
    .pkt_frameno(pkt_frameno), .pkt_addr(pkt_addr), .pkt_endp(pkt_endp),
    .rx_data(rx_data), .rx_stb(rx_stb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_start) start_cnt++;
    if (pkt_done_ok) ok_cnt++;
    if (pkt_done_err) err_cnt++;
    if (rx_stb) rx_q.push_back(rx_data);
  end

  function automatic int d_start(); return start_cnt - b_start; endfunction
  function automatic int d_ok(); return ok_cnt - b_ok; endfunction
  function automatic int d_err(); return err_cnt - b_err; endfunction
  function automatic int d_stb(); return rx_q.size() - b_q; endfunction

  function automatic logic [4:0] crc5(input logic [10:0] d);
    logic [4:0] c;
    logic fb;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[k])
      for (int i = 0; i < 8; i++) begin
        fb = q[k][i] ^ c[15];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    return c;
  endfunction

  task automatic mark();
    b_start = start_cnt; b_ok = ok_cnt; b_err = err_cnt; b_q = rx_q.size();
  endtask

  task automatic sym(input logic b, input logic sync = 0, input logic eop = 0,
                     input logic skip = 0, input logic berr = 0);
    ll_bit = b; ll_sync = sync; ll_eop = eop; ll_bs_skip = skip; ll_bs_err = berr; ll_valid = 1'b1;
    @(negedge clk);
    ll_valid = 0; ll_sync = 0; ll_eop = 0; ll_bs_skip = 0; ll_bs_err = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sym(b[i]);
  endtask

  task automatic send_crc16(input logic [15:0] c);
    for (int i = 0; i < 16; i++) sym(~c[15 - i]);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pkt_start, pkt_done_ok, pkt_done_err, pkt_pid, pkt_is_sof, pkt_is_token, pkt_is_data,
         pkt_is_handshake, pkt_frameno, pkt_addr, pkt_endp, rx_data, rx_stb} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: pid=%h frameno=%h rx_data=%h start=%b ok=%b err=%b, want all zero",
               pkt_pid, pkt_frameno, rx_data, pkt_start, pkt_done_ok, pkt_done_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack();
    mark();
    sym(0, 1);
    send_byte(8'hD2);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_start() !== 1) begin n_fail++; $display("FAIL ack_start: got %0d want 1", d_start()); end
    n_checks++; if (d_ok() !== 1) begin n_fail++; $display("FAIL ack_ok: got %0d want 1", d_ok()); end
    n_checks++; if (d_err() !== 0) begin n_fail++; $display("FAIL ack_err: got %0d want 0", d_err()); end
    n_checks++; if (d_stb() !== 0) begin n_fail++; $display("FAIL ack_stb: got %0d want 0", d_stb()); end
    n_checks++; if (pkt_pid !== 4'h2) begin n_fail++; $display("FAIL ack_pid: got %h want 2", pkt_pid); end
    n_checks++;
    if ({pkt_is_handshake, pkt_is_token, pkt_is_data, pkt_is_sof} !== 4'b1000) begin
      n_fail++; $display("FAIL ack_class: got %b want 1000",
                         {pkt_is_handshake, pkt_is_token, pkt_is_data, pkt_is_sof});
    end
  endtask

  task automatic test_sof(input logic flip);
    logic [10:0] f;
    logic [4:0] c;
    f = 11'h2A5;
    c = crc5(f);
    mark();
    sym(0, 1);
    send_byte(8'hA5);
    for (int i = 0; i < 11; i++) sym(f[i]);
    for (int i = 0; i < 5; i++) sym(~c[4 - i] ^ (flip && i == 2));
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_ok() !== (flip ? 0 : 1)) begin n_fail++; $display("FAIL sof_ok flip=%0b: got %0d want %0d", flip, d_ok(), flip ? 0 : 1); end
    n_checks++; if (d_err() !== (flip ? 1 : 0)) begin n_fail++; $display("FAIL sof_err flip=%0b: got %0d want %0d", flip, d_err(), flip ? 1 : 0); end
    n_checks++; if (d_stb() !== 0) begin n_fail++; $display("FAIL sof_stb: got %0d want 0", d_stb()); end
    if (!flip) begin
      n_checks++; if ({pkt_is_sof, pkt_is_token} !== 2'b11) begin n_fail++; $display("FAIL sof_class: got %b want 11", {pkt_is_sof, pkt_is_token}); end
      n_checks++; if (pkt_frameno !== 11'h2A5) begin n_fail++; $display("FAIL sof_frameno: got %h want 2a5", pkt_frameno); end
      n_checks++; if ({pkt_endp, pkt_addr} !== {4'h5, 7'h25}) begin n_fail++; $display("FAIL sof_endp_addr: got %h/%h want 5/25", pkt_endp, pkt_addr); end
    end
  endtask

  task automatic test_data0();
    logic [7:0] q[$];
    logic [15:0] c;
    logic [7:0] exp[5];
    q = '{8'h01, 8'h02, 8'h03};
    c = crc16(q);
    exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03;
    for (int i = 0; i < 8; i++) begin
      exp[3][i] = ~c[15 - i];
      exp[4][i] = ~c[7 - i];
    end
    mark();
    sym(0, 1);
    send_byte(8'hC3);
    foreach (q[k]) send_byte(q[k]);
    send_crc16(c);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_stb() !== 5) begin n_fail++; $display("FAIL data0_stb_count: got %0d want 5", d_stb()); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rx_q.size() <= b_q + k || rx_q[b_q + k] !== exp[k]) begin
        n_fail++; $display("FAIL data0_byte%0d: got %h want %h", k,
                           rx_q.size() > b_q + k ? rx_q[b_q + k] : 8'hxx, exp[k]);
      end
    end
    n_checks++; if (d_ok() !== 1 || d_err() !== 0) begin n_fail++; $display("FAIL data0_done: ok=%0d err=%0d want 1/0", d_ok(), d_err()); end
    n_checks++; if (pkt_pid !== 4'h3 || pkt_is_data !== 1'b1) begin n_fail++; $display("FAIL data0_pid: got %h/%b want 3/1", pkt_pid, pkt_is_data); end
  endtask

  task automatic test_stuff();
    logic [7:0] q[$];
    logic [15:0] c;
    q = '{8'hFF};
    c = crc16(q);
    mark();
    sym(0, 1);
    send_byte(8'h4B);
    for (int i = 0; i < 6; i++) sym(1);
    sym(0, 0, 0, 1);
    sym(1); sym(1);
    send_crc16(c);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_stb() !== 3) begin n_fail++; $display("FAIL stuff_stb_count: got %0d want 3", d_stb()); end
    n_checks++;
    if (rx_q.size() <= b_q || rx_q[b_q] !== 8'hFF) begin
      n_fail++; $display("FAIL stuff_byte: got %h want ff", rx_q.size() > b_q ? rx_q[b_q] : 8'hxx);
    end
    n_checks++; if (d_ok() !== 1 || d_err() !== 0) begin n_fail++; $display("FAIL stuff_done: ok=%0d err=%0d want 1/0", d_ok(), d_err()); end
    n_checks++; if (pkt_pid !== 4'hB) begin n_fail++; $display("FAIL stuff_pid: got %h want b", pkt_pid); end
  endtask

  task automatic test_bs_err();
    mark();
    sym(0, 1);
    send_byte(8'hC3);
    send_byte(8'h01);
    sym(1); sym(0); sym(1);
    sym(1, 0, 0, 0, 1);
    send_byte(8'h55);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_err() !== 1 || d_ok() !== 0) begin n_fail++; $display("FAIL bserr_done: ok=%0d err=%0d want 0/1", d_ok(), d_err()); end
    n_checks++; if (d_stb() !== 1) begin n_fail++; $display("FAIL bserr_stb: got %0d want 1", d_stb()); end
  endtask

  task automatic test_bad_pid();
    mark();
    sym(0, 1);
    send_byte(8'hC2);
    settle();
    n_checks++; if (d_err() !== 1) begin n_fail++; $display("FAIL badpid_err: got %0d want 1", d_err()); end
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_err() !== 1 || d_ok() !== 0) begin n_fail++; $display("FAIL badpid_eop: ok=%0d err=%0d want 0/1", d_ok(), d_err()); end
  endtask

  task automatic test_short();
    mark();
    sym(0, 1);
    send_byte(8'hC3);
    send_byte(8'hA7);
    sym(1); sym(1); sym(0); sym(1);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_err() !== 1 || d_ok() !== 0) begin n_fail++; $display("FAIL short_done: ok=%0d err=%0d want 0/1", d_ok(), d_err()); end
    n_checks++; if (d_stb() !== 1) begin n_fail++; $display("FAIL short_stb: got %0d want 1", d_stb()); end
  endtask

  task automatic test_hs_len();
    mark();
    sym(0, 1);
    send_byte(8'hD2);
    send_byte(8'h00);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_err() !== 1 || d_ok() !== 0) begin n_fail++; $display("FAIL hslen_done: ok=%0d err=%0d want 0/1", d_ok(), d_err()); end
  endtask

  task automatic test_sync_eop();
    mark();
    sym(0, 1, 1);
    settle();
    n_checks++; if (d_start() !== 0) begin n_fail++; $display("FAIL synceop_start: got %0d want 0", d_start()); end
  endtask

  task automatic test_abort();
    mark();
    sym(0, 1);
    send_byte(8'hC3);
    send_byte(8'h11);
    rx_enable = 1'b0;
    repeat (3) @(negedge clk);
    rx_enable = 1'b1;
    send_byte(8'h22);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_ok() !== 0 || d_err() !== 0) begin n_fail++; $display("FAIL abort_done: ok=%0d err=%0d want 0/0", d_ok(), d_err()); end
    n_checks++; if (d_stb() !== 1) begin n_fail++; $display("FAIL abort_stb: got %0d want 1", d_stb()); end
    n_checks++; if (pkt_pid !== 4'h3) begin n_fail++; $display("FAIL abort_pid_hold: got %h want 3", pkt_pid); end
    mark();
    sym(0, 1);
    send_byte(8'hD2);
    sym(0, 0, 1);
    settle();
    n_checks++; if (d_start() !== 1 || d_ok() !== 1 || d_err() !== 0) begin
      n_fail++; $display("FAIL abort_recover: start=%0d ok=%0d err=%0d want 1/1/0", d_start(), d_ok(), d_err());
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_sof(1'b0);
    test_sof(1'b1);
    test_data0();
    test_stuff();
    test_bs_err();
    test_bad_pid();
    test_short();
    test_hs_len();
    test_sync_eop();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
